id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register that sits directly upstream of the ALU and drives its
//  data1, data2, operation and ALUOp inputs. Holds one instruction slot with a valid/ready
//  handshake and resolves operand forwarding from the EX/MEM and MEM/WB stages.
//  It also keeps a held entry's operands current while downstream stalls, and supports flush
//  on branch mispredict.
// PARAMETERS
//  WIDTH      32  datapath width (ALU operands, immediate, forwarded results)
//  REGADDR_W  5   register-file address width
//  OP_W       6   ALU operation code width
// PORTS
//  clock          in   1          rising-edge clock
//  reset_n        in   1          asynchronous, active-low reset
//  inValid        in   1          decode presents an instruction
//  inReady        out  1          stage can accept this cycle
//  rs1Addr        in   REGADDR_W  source reg 1 address
//  rs2Addr        in   REGADDR_W  source reg 2 address
//  rs1Data        in   WIDTH      register-file read data 1
//  rs2Data        in   WIDTH      register-file read data 2
//  imm            in   WIDTH      sign-extended immediate
//  useImm         in   1          1: data2 = imm (no forwarding on data2)
//  operationIn    in   OP_W       ALU operation code
//  ALUOpIn        in   2          ALU mode (BEQ/BNE/pass-imm select)
//  rdIn           in   REGADDR_W  destination register
//  regWriteIn     in   1          instruction writes rdIn
//  exMemRegWrite  in   1          EX/MEM stage writes exMemRd
//  exMemRd        in   REGADDR_W  EX/MEM destination
//  exMemResult    in   WIDTH      EX/MEM result
//  memWbRegWrite  in   1          MEM/WB stage writes memWbRd
//  memWbRd        in   REGADDR_W  MEM/WB destination
//  memWbResult    in   WIDTH      MEM/WB result
//  flush          in   1          discard held entry and the current input beat
//  outReady       in   1          ALU/EX stage consumes this cycle
//  outValid       out  1          slot holds a valid instruction
//  data1          out  WIDTH      ALU operand 1
//  data2          out  WIDTH      ALU operand 2
//  operation      out  OP_W       ALU operation code
//  ALUOp          out  2          ALU mode
//  rdOut          out  REGADDR_W  destination register
//  regWriteOut    out  1          write enable (forced 0 when outValid = 0)
// BEHAVIOUR
//  - Reset (reset_n = 0, asynchronous): every registered output is 0, including outValid.
//    operation = 0 gives the ALU default pass-through.
//  - inReady = !flush && (!outValid || outReady). This is combinational; there is no bubble
//    on a back-to-back stream.
//  - Capture on the clock edge when inValid && inReady. Latency is 1 cycle, input beat to
//    outValid.
//  - Edge with outValid && outReady and no capture: outValid becomes 0.
//  - Forwarding, per operand, evaluated at capture:
//    - Source addr 0 is never forwarded; it takes the register-file data.
//    - exMemRegWrite && exMemRd == src: use exMemResult (highest priority).
//    - Otherwise memWbRegWrite && memWbRd == src: use memWbResult.
//    - Otherwise use rs1Data or rs2Data.
//    - If useImm = 1, data2 = imm and no forwarding is applied to data2.
//  - Hold snoop: while outValid && !outReady, re-apply the same forwarding rules each cycle to
//    the stored rs1/rs2 addresses. This uses internal copies of the addresses and of useImm.
//    A held operand is updated when a matching write appears, so it is never stale.
//  - Flush has priority over everything. On the edge where flush = 1:
//    - outValid <= 0 and regWriteOut <= 0.
//    - Data fields may keep their values.
//    - The input beat is not accepted (inReady = 0).
//  - Flush and outReady together: the entry counts as flushed, not consumed.
//  - Reset asserted mid-hold: the entry is lost and all outputs go to 0 immediately.
//  - operation and ALUOp pass through unchanged; no width conversion is applied.
// TESTING
//  - Reset: assert reset_n = 0 mid-stream -> all outputs 0 asynchronously; after release,
//    inReady = 1.
//  - Plain stream: 3 beats back-to-back with outReady = 1 (rs1Data = 5, rs2Data = 7,
//    operationIn = 1) -> outValid high from cycle 1, data1/data2 = 5/7 each beat, no bubbles.
//  - Forwarding priority: rs1Addr = 3, exMemRd = 3 (result 0xAA), memWbRd = 3 (result 0xBB),
//    both writes set -> data1 = 0xAA.
//  - Forwarding exclusions:
//    - rs1Addr = 0 with exMemRd = 0 -> data1 = rs1Data.
//    - useImm = 1, imm = 0x10, exMemRd = rs2Addr -> data2 = 0x10.
//  - Stall plus snoop: outReady = 0 for 3 cycles with rs2Addr = 4 held; memWbRd = 4, result
//    0x55 in stall cycle 2 -> data2 = 0x55 from the next cycle; inReady = 0 throughout; the
//    beat is consumed when outReady = 1.
//  - Flush: valid entry held, flush = 1 with inValid = 1 -> next cycle outValid = 0,
//    regWriteOut = 0, and the input beat is not captured.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side, forwarding and ALU-side signals of the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int WIDTH     = 32,
  parameter int REGADDR_W = 5,
  parameter int OP_W      = 6
);
  logic                 inValid;
  logic                 inReady;
  logic [REGADDR_W-1:0] rs1Addr;
  logic [REGADDR_W-1:0] rs2Addr;
  logic [WIDTH-1:0]     rs1Data;
  logic [WIDTH-1:0]     rs2Data;
  logic [WIDTH-1:0]     imm;
  logic                 useImm;
  logic [OP_W-1:0]      operationIn;
  logic [1:0]           ALUOpIn;
  logic [REGADDR_W-1:0] rdIn;
  logic                 regWriteIn;
  logic                 exMemRegWrite;
  logic [REGADDR_W-1:0] exMemRd;
  logic [WIDTH-1:0]     exMemResult;
  logic                 memWbRegWrite;
  logic [REGADDR_W-1:0] memWbRd;
  logic [WIDTH-1:0]     memWbResult;
  logic                 flush;
  logic                 outReady;
  logic                 outValid;
  logic [WIDTH-1:0]     data1;
  logic [WIDTH-1:0]     data2;
  logic [OP_W-1:0]      operation;
  logic [1:0]           ALUOp;
  logic [REGADDR_W-1:0] rdOut;
  logic                 regWriteOut;
  modport slave (
    input  inValid, rs1Addr, rs2Addr, rs1Data, rs2Data, imm, useImm, operationIn, ALUOpIn,
           rdIn, regWriteIn, exMemRegWrite, exMemRd, exMemResult, memWbRegWrite, memWbRd,
           memWbResult, flush, outReady,
    output inReady, outValid, data1, data2, operation, ALUOp, rdOut, regWriteOut
  );
  modport master (
    output inValid, rs1Addr, rs2Addr, rs1Data, rs2Data, imm, useImm, operationIn, ALUOpIn,
           rdIn, regWriteIn, exMemRegWrite, exMemRd, exMemResult, memWbRegWrite, memWbRd,
           memWbResult, flush, outReady,
    input  inReady, outValid, data1, data2, operation, ALUOp, rdOut, regWriteOut
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding and hold snoop
module id_ex_stage #(
  parameter int WIDTH     = 32,
  parameter int REGADDR_W = 5,
  parameter int OP_W      = 6
) (
  input logic           clock,
  input logic           reset_n,
  id_ex_stage_if.slave  p
);
  logic [REGADDR_W-1:0] rs1_q, rs2_q;
  logic                 use_imm_q;
  logic                 capture;
  logic [WIDTH-1:0]     fwd1, fwd2, snoop1, snoop2;
  function automatic logic [WIDTH-1:0] fwd(input logic [REGADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    return (a == '0) ? d :
           (p.exMemRegWrite && p.exMemRd == a) ? p.exMemResult :
           (p.memWbRegWrite && p.memWbRd == a) ? p.memWbResult : d;
  endfunction
  assign p.inReady = !p.flush && (!p.outValid || p.outReady);
  assign capture   = p.inValid && p.inReady;
  // snoop defaults to the held operand so an unmatched cycle leaves it untouched
  always_comb begin
    fwd1   = fwd(p.rs1Addr, p.rs1Data);
    fwd2   = p.useImm ? p.imm : fwd(p.rs2Addr, p.rs2Data);
    snoop1 = fwd(rs1_q, p.data1);
    snoop2 = use_imm_q ? p.data2 : fwd(rs2_q, p.data2);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p.outValid    <= 1'b0;
      p.regWriteOut <= 1'b0;
      p.data1       <= '0;
      p.data2       <= '0;
      p.operation   <= '0;
      p.ALUOp       <= '0;
      p.rdOut       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      use_imm_q     <= 1'b0;
    end else if (p.flush) begin
      p.outValid    <= 1'b0;
      p.regWriteOut <= 1'b0;
    end else if (capture) begin
      p.outValid    <= 1'b1;
      p.regWriteOut <= p.regWriteIn;
      p.data1       <= fwd1;
      p.data2       <= fwd2;
      p.operation   <= p.operationIn;
      p.ALUOp       <= p.ALUOpIn;
      p.rdOut       <= p.rdIn;
      rs1_q         <= p.rs1Addr;
      rs2_q         <= p.rs2Addr;
      use_imm_q     <= p.useImm;
    end else if (p.outValid && p.outReady) begin
      p.outValid    <= 1'b0;
      p.regWriteOut <= 1'b0;
    end else if (p.outValid) begin
      p.data1       <= snoop1;
      p.data2       <= snoop2;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for the ID/EX pipeline register
module tb_id_ex_stage;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  id_ex_stage_if p();
  id_ex_stage dut (.clock(clock), .reset_n(reset_n), .p(p));
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  op;
    logic [1:0]  alu;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic idle();
    p.inValid = 0; p.rs1Addr = 0; p.rs2Addr = 0; p.rs1Data = 0; p.rs2Data = 0;
    p.imm = 0; p.useImm = 0; p.operationIn = 0; p.ALUOpIn = 0; p.rdIn = 0; p.regWriteIn = 0;
    p.exMemRegWrite = 0; p.exMemRd = 0; p.exMemResult = 0;
    p.memWbRegWrite = 0; p.memWbRd = 0; p.memWbResult = 0;
    p.flush = 0; p.outReady = 1;
  endtask
  // one clock: check handshake and consumed beat before the edge, push capture, check outValid after
  task automatic tick(input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    logic ov, rdy;
    #1;
    ov  = sb.size() != 0;
    rdy = !p.flush && (!ov || p.outReady);
    chk("inReady", 32'(p.inReady), 32'(rdy));
    if (p.flush) begin
      if (ov) sb.delete(0);
    end else if (ov && p.outReady) begin
      e = sb.pop_front();
      chk("data1", p.data1, e.d1);
      chk("data2", p.data2, e.d2);
      chk("operation", 32'(p.operation), 32'(e.op));
      chk("ALUOp", 32'(p.ALUOp), 32'(e.alu));
      chk("rdOut", 32'(p.rdOut), 32'(e.rd));
      chk("regWriteOut", 32'(p.regWriteOut), 32'(e.rw));
    end
    if (p.inValid && rdy) begin
      e = '{d1: e1, d2: e2, op: p.operationIn, alu: p.ALUOpIn, rd: p.rdIn, rw: p.regWriteIn};
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    chk("outValid", 32'(p.outValid), 32'(sb.size() != 0));
    @(negedge clock);
  endtask
  initial begin
    idle();
    repeat (2) @(negedge clock);
    reset_n = 1;
    tick(0, 0);
    // plain back-to-back stream
    p.inValid = 1; p.rs1Addr = 1; p.rs2Addr = 2; p.rs1Data = 5; p.rs2Data = 7;
    p.operationIn = 1; p.ALUOpIn = 2; p.rdIn = 9; p.regWriteIn = 1;
    repeat (3) tick(5, 7);
    p.inValid = 0;
    tick(0, 0);
    // forwarding priority and per-operand selection
    p.inValid = 1; p.rs1Addr = 3; p.operationIn = 6'h2a; p.ALUOpIn = 1; p.rdIn = 3;
    p.exMemRegWrite = 1; p.exMemRd = 3; p.exMemResult = 32'hAA;
    p.memWbRegWrite = 1; p.memWbRd = 3; p.memWbResult = 32'hBB;
    tick(32'hAA, 7);
    p.exMemRegWrite = 0;
    tick(32'hBB, 7);
    p.exMemRegWrite = 1; p.exMemRd = 2;
    tick(32'hBB, 32'hAA);
    // address 0 never forwarded, immediate bypasses forwarding
    p.rs1Addr = 0; p.exMemRd = 0; p.memWbRd = 0;
    tick(5, 7);
    p.useImm = 1; p.imm = 32'h10; p.exMemRd = 2; p.regWriteIn = 0;
    tick(5, 32'h10);
    idle();
    tick(0, 0);
    // stall with snoop on held rs2
    p.inValid = 1; p.outReady = 0; p.rs1Addr = 1; p.rs2Addr = 4; p.rs1Data = 5; p.rs2Data = 7;
    p.operationIn = 3; p.ALUOpIn = 3; p.rdIn = 6; p.regWriteIn = 1;
    tick(5, 7);
    p.rs2Data = 32'h99;
    tick(0, 0);
    p.memWbRegWrite = 1; p.memWbRd = 4; p.memWbResult = 32'h55;
    sb[0].d2 = 32'h55;
    tick(0, 0);
    chk("snoop_data2", p.data2, 32'h55);
    p.memWbRegWrite = 0; p.memWbResult = 0;
    tick(0, 0);
    chk("snoop_keep", p.data2, 32'h55);
    p.inValid = 0; p.outReady = 1;
    tick(0, 0);
    // flush with a held entry and a presented beat
    p.inValid = 1; p.outReady = 0; p.rs2Data = 7;
    tick(5, 7);
    p.flush = 1; p.outReady = 1; p.rs1Data = 32'h33;
    tick(0, 0);
    chk("flush_regWriteOut", 32'(p.regWriteOut), 0);
    p.flush = 0; p.inValid = 0;
    tick(0, 0);
    // reset mid-hold
    p.inValid = 1; p.outReady = 0;
    tick(5, 7);
    p.inValid = 0;
    #3 reset_n = 0;
    #1;
    chk("rst_outValid", 32'(p.outValid), 0);
    chk("rst_data1", p.data1, 0);
    chk("rst_data2", p.data2, 0);
    chk("rst_operation", 32'(p.operation), 0);
    chk("rst_ALUOp", 32'(p.ALUOp), 0);
    chk("rst_rdOut", 32'(p.rdOut), 0);
    chk("rst_regWriteOut", 32'(p.regWriteOut), 0);
    sb.delete();
    @(negedge clock);
    reset_n = 1;
    tick(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
